// File: rtl/demux_rr_merge.sv
// Merges the two demux channels through per-channel FIFOs into one valid/ready
// stream tagged with its source channel, draining the FIFOs round-robin.
module demux_rr_merge #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W-1:0]             A,
  input  logic [W-1:0]             B,
  input  logic                     sel,
  input  logic                     in_valid,
  output logic [W-1:0]             out_data,
  output logic                     out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count,
  output logic                     ovf_a,
  output logic                     ovf_b,
  input  logic                     clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [W-1:0]  mem_a [DEPTH];
  logic [W-1:0]  mem_b [DEPTH];
  logic [AW-1:0] wr_a_q, rd_a_q, wr_b_q, rd_b_q;
  logic          last_grant_q;

  logic          push_req_a, push_req_b;
  logic          push_a, push_b, drop_a, drop_b;
  logic          a_ne, b_ne, load, grant_b, pop_a, pop_b;
  logic [CW-1:0] a_count_d, b_count_d;

  assign push_req_a = in_valid & ~sel;
  assign push_req_b = in_valid & sel;

  // Fullness is judged on the registered count, so a same-cycle pop never frees room.
  assign push_a = push_req_a & (a_count != FullCnt);
  assign push_b = push_req_b & (b_count != FullCnt);
  assign drop_a = push_req_a & (a_count == FullCnt);
  assign drop_b = push_req_b & (b_count == FullCnt);

  assign a_ne = (a_count != '0);
  assign b_ne = (b_count != '0);
  assign load = ~out_valid | out_ready;

  // With both channels pending, B wins only if A was granted last.
  assign grant_b = b_ne & (~a_ne | ~last_grant_q);
  assign pop_a   = load & a_ne & ~grant_b;
  assign pop_b   = load & grant_b;

  always_comb begin
    a_count_d = a_count;
    unique case ({push_a, pop_a})
      2'b10:   a_count_d = a_count + CW'(1);
      2'b01:   a_count_d = a_count - CW'(1);
      default: a_count_d = a_count;
    endcase
  end

  always_comb begin
    b_count_d = b_count;
    unique case ({push_b, pop_b})
      2'b10:   b_count_d = b_count + CW'(1);
      2'b01:   b_count_d = b_count - CW'(1);
      default: b_count_d = b_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_a) mem_a[wr_a_q] <= A;
    if (push_b) mem_b[wr_b_q] <= B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_a_q       <= '0;
      rd_a_q       <= '0;
      wr_b_q       <= '0;
      rd_b_q       <= '0;
      a_count      <= '0;
      b_count      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ch       <= 1'b0;
      last_grant_q <= 1'b1;
      ovf_a        <= 1'b0;
      ovf_b        <= 1'b0;
    end else begin
      if (push_a) wr_a_q <= wr_a_q + AW'(1);
      if (push_b) wr_b_q <= wr_b_q + AW'(1);
      if (pop_a)  rd_a_q <= rd_a_q + AW'(1);
      if (pop_b)  rd_b_q <= rd_b_q + AW'(1);
      a_count <= a_count_d;
      b_count <= b_count_d;
      if (load) begin
        if (pop_a || pop_b) begin
          out_valid    <= 1'b1;
          out_data     <= pop_b ? mem_b[rd_b_q] : mem_a[rd_a_q];
          out_ch       <= pop_b;
          last_grant_q <= pop_b;
        end else begin
          out_valid <= 1'b0;
        end
      end
      // A fresh drop outranks a simultaneous clear.
      ovf_a <= drop_a | (ovf_a & ~clr_ovf);
      ovf_b <= drop_b | (ovf_b & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_demux_rr_merge.sv
// Bench for demux_rr_merge: directed scenarios plus a randomized run against a
// queue-based model of the FIFOs, output register and round-robin grant.
module tb_demux_rr_merge;

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          sel = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_ch;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;
  logic          ovf_a;
  logic          ovf_b;
  logic          clr_ovf = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic         m_valid, m_ch, m_last, m_ovfa, m_ovfb;
  logic [W-1:0] m_data;

  demux_rr_merge #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_count   (a_count),
    .b_count   (b_count),
    .ovf_a     (ovf_a),
    .ovf_b     (ovf_b),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 1'b0;
    m_last  = 1'b1;
    m_ovfa  = 1'b0;
    m_ovfb  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit load, full_a, full_b, drop_a, drop_b;
    int g;
    load   = !m_valid || out_ready;
    full_a = (qa.size() == DEPTH);
    full_b = (qb.size() == DEPTH);
    g = -1;
    if (load) begin
      if (qa.size() > 0 && qb.size() > 0) g = (m_last == 1'b1) ? 0 : 1;
      else if (qa.size() > 0)             g = 0;
      else if (qb.size() > 0)             g = 1;
    end
    if (load) begin
      if (g == 0) begin
        m_data = qa.pop_front(); m_ch = 1'b0; m_valid = 1'b1; m_last = 1'b0;
      end else if (g == 1) begin
        m_data = qb.pop_front(); m_ch = 1'b1; m_valid = 1'b1; m_last = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    drop_a = in_valid && !sel && full_a;
    drop_b = in_valid && sel && full_b;
    if (in_valid && !sel && !full_a) qa.push_back(A);
    if (in_valid && sel && !full_b)  qb.push_back(B);
    m_ovfa = drop_a ? 1'b1 : (clr_ovf ? 1'b0 : m_ovfa);
    m_ovfb = drop_b ? 1'b1 : (clr_ovf ? 1'b0 : m_ovfb);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push(input logic s, input logic [W-1:0] d);
    in_valid = 1'b1;
    sel      = s;
    if (s) begin
      B = d; A = W'($urandom);
    end else begin
      A = d; B = W'($urandom);
    end
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%0b d=%0h ch=%0b want 0/0/0", out_valid, out_data, out_ch);
    end
    compared++;
    if (a_count !== '0 || b_count !== '0 || ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: got ac=%0d bc=%0d ovf=%0b%0b want 0 0 00",
               a_count, b_count, ovf_a, ovf_b);
    end
    // Build up state, then assert reset between clock edges.
    for (int i = 1; i <= 6; i++) push(1'b0, W'(i));
    push(1'b1, 4'h3);
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || a_count !== '0 || b_count !== '0 || ovf_a !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: got v=%0b ac=%0d bc=%0d ovf_a=%0b want 0 0 0 0",
               out_valid, a_count, b_count, ovf_a);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_discard: got out_valid=%0b want 0", out_valid);
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    out_ready = 1'b1;
    push(1'b0, 4'h5);
    compared++;
    if (out_valid !== 1'b0 || a_count !== CW'(1)) begin
      mismatched++;
      $display("FAIL latency_edge_k: got v=%0b ac=%0d want 0 1", out_valid, a_count);
    end
    cycle();
    compared++;
    if (out_valid !== 1'b1 || out_data !== 4'h5 || out_ch !== 1'b0 || a_count !== '0) begin
      mismatched++;
      $display("FAIL latency_edge_k1: got v=%0b d=%0h ch=%0b ac=%0d want 1 5 0 0",
               out_valid, out_data, out_ch, a_count);
    end
    cycle();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL latency_drain: got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_d [4] = '{4'h1, 4'h9, 4'h2, 4'hA};
    logic         exp_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    push(1'b0, 4'h1);
    push(1'b0, 4'h2);
    push(1'b1, 4'h9);
    push(1'b1, 4'hA);
    compared++;
    if (a_count !== CW'(1) || b_count !== CW'(2)) begin
      mismatched++;
      $display("FAIL rr_counts: got ac=%0d bc=%0d want 1 2", a_count, b_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (out_valid !== 1'b1 || out_ch !== exp_c[i] || out_data !== exp_d[i]) begin
        mismatched++;
        $display("FAIL rr_order[%0d]: got v=%0b (%0b,%0h) want 1 (%0b,%0h)",
                 i, out_valid, out_ch, out_data, exp_c[i], exp_d[i]);
      end
      cycle();
    end
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rr_empty: got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      push(1'b0, W'(i));
      if (i == 5) begin
        compared++;
        if (ovf_a !== 1'b0 || a_count !== CW'(DEPTH)) begin
          mismatched++;
          $display("FAIL ovf_before_drop: got ovf_a=%0b ac=%0d want 0 %0d", ovf_a, a_count, DEPTH);
        end
      end
    end
    compared++;
    if (a_count !== CW'(DEPTH) || ovf_a !== 1'b1 || ovf_b !== 1'b0 || out_data !== 4'h1) begin
      mismatched++;
      $display("FAIL ovf_after_drop: got ac=%0d ovf=%0b%0b d=%0h want %0d 10 1",
               a_count, ovf_a, ovf_b, out_data, DEPTH);
    end
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    compared++;
    if (ovf_a !== 1'b0 || a_count !== CW'(DEPTH)) begin
      mismatched++;
      $display("FAIL ovf_clear: got ovf_a=%0b ac=%0d want 0 %0d", ovf_a, a_count, DEPTH);
    end
    clr_ovf = 1'b1;
    push(1'b0, 4'h7);
    clr_ovf = 1'b0;
    compared++;
    if (ovf_a !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_clear_vs_drop: got ovf_a=%0b want 1", ovf_a);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      compared++;
      if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        mismatched++;
        $display("FAIL ovf_drain[%0d]: got v=%0b d=%0h want 1 %0h", i, out_valid, out_data, i);
      end
      cycle();
    end
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL ovf_drained: got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    for (int i = 1; i <= 5; i++) push(1'b1, W'(i));
    compared++;
    if (b_count !== CW'(DEPTH) || ovf_b !== 1'b0) begin
      mismatched++;
      $display("FAIL b_full: got bc=%0d ovf_b=%0b want %0d 0", b_count, ovf_b, DEPTH);
    end
    out_ready = 1'b1;
    push(1'b1, 4'h7);
    compared++;
    if (b_count !== CW'(DEPTH - 1) || ovf_b !== 1'b1 || ovf_a !== 1'b0 || out_data !== 4'h2) begin
      mismatched++;
      $display("FAIL b_pop_push_full: got bc=%0d ovf=%0b%0b d=%0h want %0d 01 2",
               b_count, ovf_a, ovf_b, out_data, DEPTH - 1);
    end
    for (int i = 3; i <= 5; i++) begin
      cycle();
      compared++;
      if (out_valid !== 1'b1 || out_data !== W'(i) || out_ch !== 1'b1) begin
        mismatched++;
        $display("FAIL b_drain[%0d]: got v=%0b ch=%0b d=%0h want 1 1 %0h",
                 i, out_valid, out_ch, out_data, i);
      end
    end
    cycle();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL b_drained: got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(i[0], W'(i));
      in_valid = 1'b1;
      if (i >= 1) begin
        compared++;
        if (out_valid !== 1'b1 || out_data !== W'(i - 1) || out_ch !== i[0] ^ 1'b1) begin
          mismatched++;
          $display("FAIL b2b[%0d]: got v=%0b ch=%0b d=%0h want 1 %0b %0h",
                   i, out_valid, out_ch, out_data, i[0] ^ 1'b1, i - 1);
        end
      end
    end
    in_valid = 1'b0;
    cycle();
    compared++;
    if (out_valid !== 1'b1 || out_data !== 4'h7) begin
      mismatched++;
      $display("FAIL b2b_last: got v=%0b d=%0h want 1 7", out_valid, out_data);
    end
  endtask

  task automatic test_random();
    int     pushes = 0;
    int     drain  = 0;
    logic   stalled;
    logic [W-1:0] prev_d;
    logic   prev_c;
    do_reset();
    while (drain < 12) begin
      if (pushes < 100) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        sel       = 1'($urandom);
        A         = W'($urandom);
        B         = W'($urandom);
        out_ready = ($urandom_range(0, 9) < 5);
        clr_ovf   = ($urandom_range(0, 15) == 0);
        if (in_valid) pushes++;
      end else begin
        in_valid  = 1'b0;
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        drain++;
      end
      stalled = out_valid && !out_ready;
      prev_d  = out_data;
      prev_c  = out_ch;
      cycle();
      compared++;
      if (out_valid !== m_valid || out_data !== m_data || out_ch !== m_ch) begin
        mismatched++;
        $display("FAIL rand_out: got v=%0b ch=%0b d=%0h want v=%0b ch=%0b d=%0h",
                 out_valid, out_ch, out_data, m_valid, m_ch, m_data);
      end
      compared++;
      if (a_count !== CW'(qa.size()) || b_count !== CW'(qb.size())) begin
        mismatched++;
        $display("FAIL rand_counts: got ac=%0d bc=%0d want %0d %0d",
                 a_count, b_count, qa.size(), qb.size());
      end
      compared++;
      if (ovf_a !== m_ovfa || ovf_b !== m_ovfb) begin
        mismatched++;
        $display("FAIL rand_ovf: got %0b%0b want %0b%0b", ovf_a, ovf_b, m_ovfa, m_ovfb);
      end
      if (stalled) begin
        compared++;
        if (out_valid !== 1'b1 || out_data !== prev_d || out_ch !== prev_c) begin
          mismatched++;
          $display("FAIL rand_stall_hold: got v=%0b ch=%0b d=%0h want 1 %0b %0h",
                   out_valid, out_ch, out_data, prev_c, prev_d);
        end
      end
    end
    compared++;
    if (out_valid !== 1'b0 || a_count !== '0 || b_count !== '0) begin
      mismatched++;
      $display("FAIL rand_final_empty: got v=%0b ac=%0d bc=%0d want 0 0 0",
               out_valid, a_count, b_count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_full_pop_push();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
